mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum RAM wait cycles per access before forced completion.
REQ-002 Parameter ERR_WORD, default 32'hBAD1BAD1: load value returned on a timed-out read.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 nRST  in  1  reset; asynchronous, active-low.
REQ-005 iREN  in  1  instruction fetch request from the pipeline fetch stage.
REQ-006 iaddr  in  32  instruction word address.
REQ-007 dREN  in  1  data read request from the memory stage.
REQ-008 dWEN  in  1  data write request from the memory stage.
REQ-009 daddr  in  32  data address.
REQ-010 dstore  in  32  data write value.
REQ-011 ihit  out  1  instruction access complete; feeds the hazard unit.
REQ-012 dhit  out  1  data access complete; feeds the hazard unit.
REQ-013 iload  out  32  fetched instruction, valid while ihit is high.
REQ-014 dload  out  32  read data, valid while dhit is high.
REQ-015 ramREN  out  1  RAM read strobe.
REQ-016 ramWEN  out  1  RAM write strobe.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data, valid when ram_rdy is high.
REQ-020 ram_rdy  in  1  RAM access complete, single-cycle pulse.
REQ-021 mem_err  out  1  sticky flag: at least one access has timed out.

Function
REQ-022 FSM states: IDLE, IBUSY, DBUSY, DONE; single-port RAM, one outstanding access.
REQ-023 IDLE: only data pending -> DBUSY; only iREN -> IBUSY; both pending -> the side not granted last (last_grant bit), so neither side starves.
REQ-024 On grant, register the address, dstore, and access type (read/write); RAM outputs are driven from these registers, not from live inputs.
REQ-025 dREN and dWEN both high: treated as a write.
REQ-026 In IBUSY/DBUSY: hold ramREN (read) or ramWEN (write) high and the address/data stable until ram_rdy, or until timeout.
REQ-027 On ram_rdy in a BUSY state: capture ramload into the load register of the granted side, then -> DONE; strobes drop on the following edge.
REQ-028 Wait counter: clears on grant and increments each BUSY cycle without ram_rdy; reaching TIMEOUT forces -> DONE, sets mem_err, and loads ERR_WORD (reads only).
REQ-029 DONE lasts exactly one cycle: assert ihit or dhit for the granted side, update last_grant, then -> IDLE.
REQ-030 Minimum latency: request in cycle 0, grant edge, ram_rdy in cycle 1, hit in cycle 2.
REQ-031 ihit and dhit are registered, never high together, and never high for more than one consecutive cycle.
REQ-032 A request withdrawn during BUSY does not abort the access; the RAM access completes and the hit still pulses.
REQ-033 ram_rdy in IDLE or DONE is ignored.
REQ-034 iload/dload hold their last value until overwritten; write accesses do not modify dload.
REQ-035 mem_err is cleared only by reset.

Reset
REQ-036 nRST low, immediately and asynchronously: state=IDLE; hits, strobes, mem_err, last_grant, and the counter all 0; addresses, store, and loads all 32'h0.
REQ-037 Reset asserted mid-access abandons the access, and RAM strobes deassert without waiting for a clock edge.
REQ-038 The first grant after reset favours data when both requests are pending (last_grant=instruction).

Verification
REQ-039 iREN, iaddr=0x40, ram_rdy one cycle after grant, ramload=0x8C010004 -> ramREN and ramaddr=0x40 for 1 cycle; ihit for 1 cycle with iload=0x8C010004.
REQ-040 iREN and dREN together, continuously, for 4 accesses -> grants alternate D, I, D, I; each hit is a single-cycle pulse; ihit and dhit are never high together.
REQ-041 dWEN, daddr=0x100, dstore=0xDEADBEEF, ram_rdy after 3 cycles -> ramWEN high 3 cycles with stable address/data; dhit 1 cycle; dload unchanged.
REQ-042 dREN with ram_rdy never asserted -> dhit exactly TIMEOUT cycles after grant plus 1; dload=0xBAD1BAD1; mem_err=1 and stays 1.
REQ-043 nRST pulsed low during DBUSY -> strobes 0 before the next edge, no hit pulse; the next request is serviced normally.
REQ-044 Spurious ram_rdy in IDLE, and a request dropped mid-BUSY -> the spurious pulse has no effect; the dropped access still completes with its hit pulse.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Pipeline/RAM bus seen by the memory arbiter.
// master = arbiter side, slave = pipeline + RAM side.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_rdy;
  logic        mem_err;

  modport master (
    input  iREN, iaddr, dREN, dWEN,
    input  daddr, dstore,
    input  ramload, ram_rdy,
    output ihit, dhit, iload, dload,
    output ramREN, ramWEN,
    output ramaddr, ramstore,
    output mem_err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN,
    output daddr, dstore,
    output ramload, ram_rdy,
    input  ihit, dhit, iload, dload,
    input  ramREN, ramWEN,
    input  ramaddr, ramstore,
    input  mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and memory stages.
// One access in flight, fair I/D alternation, timeout guard.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    IBUSY,
    DBUSY,
    DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_d;
  logic          r_gnt_d;
  logic          r_wr;
  logic          r_ihit;
  logic          r_dhit;
  logic [31:0]   r_iload;
  logic [31:0]   r_dload;
  logic          r_ren;
  logic          r_wen;
  logic [31:0]   r_addr;
  logic [31:0]   r_store;
  logic          r_err;

  logic          w_dreq;
  logic          w_pick_d;
  logic          w_tmo;
  logic          w_end;
  logic [31:0]   w_ld;

  assign w_dreq   = bus.dREN | bus.dWEN;
  // r_last_d==0 means instruction went last, so data wins a tie
  assign w_pick_d = w_dreq & (~bus.iREN | ~r_last_d);
  assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));
  assign w_end    = bus.ram_rdy | w_tmo;
  assign w_ld     = bus.ram_rdy ? bus.ramload : ERR_WORD;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last_d <= 1'b0;
      r_gnt_d  <= 1'b0;
      r_wr     <= 1'b0;
      r_ihit   <= 1'b0;
      r_dhit   <= 1'b0;
      r_iload  <= 32'h0;
      r_dload  <= 32'h0;
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_addr   <= 32'h0;
      r_store  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      r_ihit <= 1'b0;
      r_dhit <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_dreq | bus.iREN) begin
            r_cnt   <= '0;
            r_gnt_d <= w_pick_d;
            if (w_pick_d) begin
              r_state <= DBUSY;
              r_addr  <= bus.daddr;
              r_store <= bus.dstore;
              r_wr    <= bus.dWEN;
              r_ren   <= ~bus.dWEN;
              r_wen   <= bus.dWEN;
            end else begin
              r_state <= IBUSY;
              r_addr  <= bus.iaddr;
              r_wr    <= 1'b0;
              r_ren   <= 1'b1;
              r_wen   <= 1'b0;
            end
          end
        end
        IBUSY, DBUSY: begin
          if (w_end) begin
            r_state <= DONE;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            if (!bus.ram_rdy) r_err <= 1'b1;
            if (r_gnt_d) begin
              r_dhit <= 1'b1;
              if (!r_wr) r_dload <= w_ld;
            end else begin
              r_ihit  <= 1'b1;
              r_iload <= w_ld;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_last_d <= r_gnt_d;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ihit     = r_ihit;
  assign bus.dhit     = r_dhit;
  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;
  assign bus.ramREN   = r_ren;
  assign bus.ramWEN   = r_wen;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_store;
  assign bus.mem_err  = r_err;

endmodule
